kbd_joypad: RTL and testbench
=============================

KBD_JOYPAD -- requirements
Module: kbd_joypad

Interface
REQ-001 SHALL have parameter PLAYERS, default 2, number of joypad channels, legal range 1..4.
REQ-002 SHALL have parameter BUTTONS, default 8, bits per pad; only 8 legal, range-checked at elaboration.
REQ-003 SHALL have port clock  in  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port ps2_hit  in  1  one-cycle pulse, ps2_data valid.
REQ-006 SHALL have port ps2_data  in  8  received PS/2 set-2 byte.
REQ-007 SHALL have port strobe  in  1  level; CPU $4016 bit0 latch (shared by all pads).
REQ-008 SHALL have port rd  in  PLAYERS  one-cycle read pulse per pad ($4016/$4017 read).
REQ-009 SHALL have port dout  out  PLAYERS  registered serial data bit per pad.
REQ-010 SHALL have port joy  out  PLAYERS*8  live button state; pad p at [p*8 +: 8].

Function
REQ-011 SHALL order bits per pad: 0=A, 1=B, 2=Select, 3=Start, 4=Up, 5=Down, 6=Left, 7=Right; 1=pressed.
REQ-012 SHALL run a scancode FSM, states IDLE, EXT, BRK, EXTBRK, advancing only on ps2_hit.
REQ-013 SHALL transition: IDLE+E0->EXT; IDLE+F0->BRK; EXT+F0->EXTBRK; any other byte applies make (IDLE/EXT) or break (BRK/EXTBRK), then ->IDLE.
REQ-014 SHALL map pad0: A=1A, B=22, Sel=21, Sta=2A, Up=E0 75, Down=E0 72, Left=E0 6B, Right=E0 74.
REQ-015 SHALL map pad1: A=42, B=3B, Sel=33, Sta=34, Up=1D, Down=1B, Left=1C, Right=23 (non-extended).
REQ-016 SHALL map pad2: A=71, B=70, Sel=E0 4A, Sta=7C, Up=75, Down=72, Left=6B, Right=74 (non-extended keypad); pad3 unmapped, constant 0.
REQ-017 SHALL distinguish extended from non-extended codes: E0 75 touches only pad0 Up; bare 75 touches only pad2 Up.
REQ-018 SHALL ignore unmapped bytes (incl. E1, AA, FA, FE) except for returning FSM to IDLE; mappings for pads >= PLAYERS are dropped.
REQ-019 SHALL update joy one clock after the ps2_hit carrying the final byte.
REQ-020 SHALL, while strobe=1, reload each pad shift register from its joy value every clock; rd ignored.
REQ-021 SHALL, while strobe=0 and rd[p]=1, shift pad p right one bit, filling bit7 with 1.
REQ-022 SHALL drive dout[p] = shift register bit0; after 8 reads without strobe, dout[p]=1 for all further reads.
REQ-023 SHALL, on same-cycle key event and strobe reload, load the pre-update joy value (new value visible next reload).
REQ-024 SHALL keep pads independent: rd on one pad never shifts another.

Reset
REQ-025 SHALL, on reset, clear all button state, shift registers and dout to 0, FSM to IDLE.
REQ-026 SHALL let reset override ps2_hit, strobe and rd in the same cycle; partial E0/F0 prefix is discarded.

Configuration
REQ-027 SHALL, with KBD_JOYPAD_SOCD_EN defined, report Up and Down as 0 in joy and shift loads when both held; likewise Left/Right; held state preserved internally, so release of one restores the other.
REQ-028 SHALL, without KBD_JOYPAD_SOCD_EN, report raw held state, opposing directions simultaneously allowed.

Verification
REQ-029 SHALL cover: bytes 1A, then strobe 1->0 -> joy[7:0]=01, dout[0]=1, 7 rd -> dout[0]=0, 8th rd -> dout[0]=1 thereafter.
REQ-030 SHALL cover: E0 75 then 75 -> joy[7:0]=10 and joy[15:8]=00 with PLAYERS=2 (pad2 dropped); with PLAYERS=3 joy[23:16]=10.
REQ-031 SHALL cover: make 22, then F0 22 -> joy[1] rises then clears one clock after final byte; E0 F0 74 clears joy[7] only.
REQ-032 SHALL cover: 1D and 1B held, SOCD_EN defined -> joy[12]=joy[13]=0; send F0 1B -> joy[12]=1; undefined -> both 1.
REQ-033 SHALL cover: reset asserted after E0 byte, then 75 -> joy[4]=0, joy[20]=1 (PLAYERS=3), dout=0 until strobe.
REQ-034 SHALL cover: strobe=1 with rd[0] pulsed -> dout[0] stays joy[0]; rd[1] with strobe=0 shifts pad1 only.

Source files
------------

// File: rtl/kbd_joypad_if.sv
// kbd_joypad_if -- bus between a PS/2 receiver / CPU port decoder and the
// keyboard-to-joypad bridge.
//   ps2_hit   one-cycle pulse, ps2_data valid
//   ps2_data  received PS/2 set-2 byte
//   strobe    level, shared latch for all pads
//   rd        one-cycle read pulse per pad
//   dout      registered serial data bit per pad
//   joy       live button state, pad p at [p*8 +: 8]
// master: drives the PS/2 byte stream and CPU strobe/reads.
// slave : the bridge itself.

interface kbd_joypad_if #(
  parameter int PLAYERS = 2
);
  logic                   ps2_hit;
  logic [7:0]             ps2_data;
  logic                   strobe;
  logic [PLAYERS-1:0]     rd;
  logic [PLAYERS-1:0]     dout;
  logic [PLAYERS*8-1:0]   joy;

  modport master (
    output ps2_hit, ps2_data, strobe, rd,
    input  dout, joy
  );

  modport slave (
    input  ps2_hit, ps2_data, strobe, rd,
    output dout, joy
  );
endinterface

// File: rtl/kbd_joypad.sv
// kbd_joypad -- turns PS/2 set-2 make/break codes into up to four NES-style
// joypads (8 buttons each: A, B, Select, Start, Up, Down, Left, Right),
// each readable through a strobe-latched serial shift register.
//
// Ports
//   clock   sole clock, rising edge
//   reset   synchronous, active-high
//   bus     kbd_joypad_if.slave (ps2_hit, ps2_data, strobe, rd, dout, joy)
//
// Parameters
//   PLAYERS  number of pads, 1..4 (pad 3 has no key mapping, reads 0)
//   BUTTONS  bits per pad, must be 8
//
// Optional feature
//   KBD_JOYPAD_SOCD_EN  when defined, opposing directions held together are
//                       both reported released; held state is kept so that
//                       releasing one key restores the other.
//
// Scancode FSM
//   state    | meaning
//   S_IDLE   | no prefix pending
//   S_EXT    | E0 seen, next byte is an extended make
//   S_BRK    | F0 seen, next byte is a normal break
//   S_EXTBRK | E0 F0 seen, next byte is an extended break

module kbd_joypad #(
  parameter int PLAYERS = 2,
  parameter int BUTTONS = 8
) (
  input logic         clock,
  input logic         reset,
  kbd_joypad_if.slave bus
);

  if (PLAYERS < 1 || PLAYERS > 4 || BUTTONS != 8) begin : g_param_check
    $error("kbd_joypad: PLAYERS must be 1..4 and BUTTONS must be 8");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXT,
    S_BRK,
    S_EXTBRK
  } state_t;

  state_t state_q, state_d;

  logic [PLAYERS-1:0][BUTTONS-1:0] held_q, held_d;
  logic [PLAYERS-1:0][BUTTONS-1:0] shift_q, shift_d;
  logic [PLAYERS-1:0][BUTTONS-1:0] view;

  logic       is_ext;
  logic       key_valid;
  logic [1:0] key_pad;
  logic [2:0] key_btn;
  logic       apply_key;
  logic       make_key;

  // Result: {valid, pad[1:0], button[2:0]}
  function automatic logic [5:0] decode(input logic ext, input logic [7:0] code);
    logic [5:0] r;
    r = 6'd0;
    case ({ext, code})
      // pad 0
      {1'b0, 8'h1A}: r = {1'b1, 2'd0, 3'd0};
      {1'b0, 8'h22}: r = {1'b1, 2'd0, 3'd1};
      {1'b0, 8'h21}: r = {1'b1, 2'd0, 3'd2};
      {1'b0, 8'h2A}: r = {1'b1, 2'd0, 3'd3};
      {1'b1, 8'h75}: r = {1'b1, 2'd0, 3'd4};
      {1'b1, 8'h72}: r = {1'b1, 2'd0, 3'd5};
      {1'b1, 8'h6B}: r = {1'b1, 2'd0, 3'd6};
      {1'b1, 8'h74}: r = {1'b1, 2'd0, 3'd7};
      // pad 1
      {1'b0, 8'h42}: r = {1'b1, 2'd1, 3'd0};
      {1'b0, 8'h3B}: r = {1'b1, 2'd1, 3'd1};
      {1'b0, 8'h33}: r = {1'b1, 2'd1, 3'd2};
      {1'b0, 8'h34}: r = {1'b1, 2'd1, 3'd3};
      {1'b0, 8'h1D}: r = {1'b1, 2'd1, 3'd4};
      {1'b0, 8'h1B}: r = {1'b1, 2'd1, 3'd5};
      {1'b0, 8'h1C}: r = {1'b1, 2'd1, 3'd6};
      {1'b0, 8'h23}: r = {1'b1, 2'd1, 3'd7};
      // pad 2 (keypad; Select is the extended keypad slash)
      {1'b0, 8'h71}: r = {1'b1, 2'd2, 3'd0};
      {1'b0, 8'h70}: r = {1'b1, 2'd2, 3'd1};
      {1'b1, 8'h4A}: r = {1'b1, 2'd2, 3'd2};
      {1'b0, 8'h7C}: r = {1'b1, 2'd2, 3'd3};
      {1'b0, 8'h75}: r = {1'b1, 2'd2, 3'd4};
      {1'b0, 8'h72}: r = {1'b1, 2'd2, 3'd5};
      {1'b0, 8'h6B}: r = {1'b1, 2'd2, 3'd6};
      {1'b0, 8'h74}: r = {1'b1, 2'd2, 3'd7};
      default:       r = 6'd0;
    endcase
    return r;
  endfunction

  function automatic logic [BUTTONS-1:0] socd(input logic [BUTTONS-1:0] h);
    logic [BUTTONS-1:0] r;
    r = h;
`ifdef KBD_JOYPAD_SOCD_EN
    if (h[4] && h[5]) r[5:4] = 2'b00;
    if (h[6] && h[7]) r[7:6] = 2'b00;
`else
    r = h;
`endif
    return r;
  endfunction

  assign is_ext = (state_q == S_EXT) || (state_q == S_EXTBRK);
  assign {key_valid, key_pad, key_btn} = decode(is_ext, bus.ps2_data);

  always_comb begin
    state_d   = state_q;
    held_d    = held_q;
    apply_key = 1'b0;
    make_key  = 1'b0;
    if (bus.ps2_hit) begin
      case (state_q)
        S_IDLE: begin
          if (bus.ps2_data == 8'hE0) begin
            state_d = S_EXT;
          end else if (bus.ps2_data == 8'hF0) begin
            state_d = S_BRK;
          end else begin
            apply_key = 1'b1;
            make_key  = 1'b1;
          end
        end
        S_EXT: begin
          if (bus.ps2_data == 8'hF0) begin
            state_d = S_EXTBRK;
          end else begin
            apply_key = 1'b1;
            make_key  = 1'b1;
            state_d   = S_IDLE;
          end
        end
        default: begin
          apply_key = 1'b1;
          state_d   = S_IDLE;
        end
      endcase
    end
    // Mappings that land on a pad this instance does not have are dropped.
    if (apply_key && key_valid) begin
      for (int p = 0; p < PLAYERS; p++) begin
        if (key_pad == 2'(p)) held_d[p][key_btn] = make_key;
      end
    end
  end

  // Shift registers reload from the currently visible state, so a key event
  // landing on the same edge as a reload shows up only on the next reload.
  always_comb begin
    for (int p = 0; p < PLAYERS; p++) begin
      view[p] = socd(held_q[p]);
      if (bus.strobe) begin
        shift_d[p] = view[p];
      end else if (bus.rd[p]) begin
        shift_d[p] = {1'b1, shift_q[p][BUTTONS-1:1]};
      end else begin
        shift_d[p] = shift_q[p];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      held_q  <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      held_q  <= held_d;
      shift_q <= shift_d;
    end
  end

  assign bus.joy = view;

  for (genvar g = 0; g < PLAYERS; g++) begin : g_dout
    assign bus.dout[g] = shift_q[g][0];
  end

endmodule

// File: tb/tb_kbd_joypad.sv
module tb_kbd_joypad;

  logic       clock = 1'b0;
  logic       reset;
  logic       hit;
  logic [7:0] data;
  logic       strobe;
  logic [2:0] rd;

  kbd_joypad_if #(.PLAYERS(2)) bus2 ();
  kbd_joypad_if #(.PLAYERS(3)) bus3 ();

  assign bus2.ps2_hit  = hit;
  assign bus2.ps2_data = data;
  assign bus2.strobe   = strobe;
  assign bus2.rd       = rd[1:0];
  assign bus3.ps2_hit  = hit;
  assign bus3.ps2_data = data;
  assign bus3.strobe   = strobe;
  assign bus3.rd       = rd;

  kbd_joypad #(.PLAYERS(2), .BUTTONS(8)) u_dut2 (.clock(clock), .reset(reset), .bus(bus2));
  kbd_joypad #(.PLAYERS(3), .BUTTONS(8)) u_dut3 (.clock(clock), .reset(reset), .bus(bus3));

  always #5 clock = ~clock;

  int n_assert = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Key table: entry pad*8+button holds {extended, code}.
  function automatic int find_key(input bit ext, input logic [7:0] code);
    logic [8:0] tbl [24];
    tbl = '{9'h01A, 9'h022, 9'h021, 9'h02A, 9'h175, 9'h172, 9'h16B, 9'h174,
            9'h042, 9'h03B, 9'h033, 9'h034, 9'h01D, 9'h01B, 9'h01C, 9'h023,
            9'h071, 9'h070, 9'h14A, 9'h07C, 9'h075, 9'h072, 9'h06B, 9'h074};
    for (int i = 0; i < 24; i++)
      if (tbl[i] == {ext, code}) return i;
    return -1;
  endfunction

  // What a pad reports given what is held.
  function automatic logic [7:0] m_view(input logic [7:0] h);
    logic [7:0] r;
    r = h;
`ifdef KBD_JOYPAD_SOCD_EN
    if (h[4] == 1'b1 && h[5] == 1'b1) begin r[4] = 1'b0; r[5] = 1'b0; end
    if (h[6] == 1'b1 && h[7] == 1'b1) begin r[6] = 1'b0; r[7] = 1'b0; end
`endif
    return r;
  endfunction

  logic [7:0] m_held [3];
  logic [7:0] m_sh   [3];
  bit         m_ext;
  bit         m_brk;

  always @(posedge clock) begin
    if (reset) begin
      for (int p = 0; p < 3; p++) begin m_held[p] = 8'h00; m_sh[p] = 8'h00; end
      m_ext = 1'b0;
      m_brk = 1'b0;
    end else begin
      for (int p = 0; p < 3; p++) begin
        if (strobe) m_sh[p] = m_view(m_held[p]);
        else if (rd[p]) m_sh[p] = (m_sh[p] >> 1) | 8'h80;
      end
      if (hit) begin
        if (data == 8'hE0 && !m_ext && !m_brk) m_ext = 1'b1;
        else if (data == 8'hF0 && !m_brk) m_brk = 1'b1;
        else begin
          int k;
          k = find_key(m_ext, data);
          if (k >= 0) m_held[k / 8][k % 8] = !m_brk;
          m_ext = 1'b0;
          m_brk = 1'b0;
        end
      end
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      for (int p = 0; p < 3; p++) begin
        check($sformatf("model joy3 pad%0d", p), 32'(bus3.joy[p*8 +: 8]), 32'(m_view(m_held[p])));
        check($sformatf("model dout3 pad%0d", p), 32'(bus3.dout[p]), 32'(m_sh[p][0]));
      end
      for (int p = 0; p < 2; p++) begin
        check($sformatf("model joy2 pad%0d", p), 32'(bus2.joy[p*8 +: 8]), 32'(m_view(m_held[p])));
        check($sformatf("model dout2 pad%0d", p), 32'(bus2.dout[p]), 32'(m_sh[p][0]));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [7:0] b);
    @(negedge clock); hit = 1'b1; data = b;
    @(negedge clock); hit = 1'b0;
  endtask

  task automatic latch();
    @(negedge clock); strobe = 1'b1;
    @(negedge clock); strobe = 1'b0;
  endtask

  task automatic rd_pulse(input logic [2:0] m);
    @(negedge clock); rd = m;
    @(negedge clock); rd = 3'b000;
  endtask

  initial begin
    reset = 1'b1; hit = 1'b0; data = 8'h00; strobe = 1'b0; rd = 3'b000;
    @(negedge clock);
    chk_en = 1'b1;
    @(negedge clock);
    check("reset joy3", 32'(bus3.joy), 32'h0);
    check("reset dout3", 32'(bus3.dout), 32'h0);
    reset = 1'b0;

    // A on pad 0, then serial readout
    send(8'h1A);
    check("1A joy pad0", 32'(bus3.joy[7:0]), 32'h01);
    latch();
    check("latched dout0", 32'(bus3.dout[0]), 32'h1);
    repeat (7) rd_pulse(3'b001);
    check("7 reads dout0", 32'(bus3.dout[0]), 32'h0);
    rd_pulse(3'b001);
    check("8 reads dout0", 32'(bus3.dout[0]), 32'h1);
    rd_pulse(3'b001);
    check("9 reads dout0", 32'(bus3.dout[0]), 32'h1);

    // extended vs bare keypad 8
    send(8'hF0); send(8'h1A);
    send(8'hE0); send(8'h75);
    send(8'h75);
    check("ext/bare joy2", 32'(bus2.joy), 32'h0010);
    check("ext/bare joy3", 32'(bus3.joy), 32'h100010);

    // make / break timing
    send(8'h22);
    check("22 make", 32'(bus3.joy[1]), 32'h1);
    send(8'hF0);
    check("22 F0 pending", 32'(bus3.joy[1]), 32'h1);
    send(8'h22);
    check("22 break", 32'(bus3.joy[1]), 32'h0);
    send(8'hE0); send(8'h74);
    check("E0 74 make", 32'(bus3.joy[7:0]), 32'h90);
    send(8'hE0); send(8'hF0); send(8'h74);
    check("E0 F0 74 pad0", 32'(bus3.joy[7:0]), 32'h10);
    check("E0 F0 74 pad2", 32'(bus3.joy[23:16]), 32'h10);

    // opposing directions on pad 1
    send(8'h1D); send(8'h1B);
`ifdef KBD_JOYPAD_SOCD_EN
    check("up+down pad1", 32'(bus3.joy[15:8]), 32'h00);
`else
    check("up+down pad1", 32'(bus3.joy[15:8]), 32'h30);
`endif
    send(8'hF0); send(8'h1B);
    check("down released", 32'(bus3.joy[12]), 32'h1);

    // strobe high ignores rd; rd on pad 1 shifts pad 1 only
    send(8'h1A);
    @(negedge clock); strobe = 1'b1;
    rd_pulse(3'b001);
    rd_pulse(3'b001);
    check("strobe holds dout0", 32'(bus3.dout[0]), 32'h1);
    @(negedge clock); strobe = 1'b0;
    repeat (3) rd_pulse(3'b010);
    check("pad1 3 shifts", 32'(bus3.dout), 32'h1);
    rd_pulse(3'b010);
    check("pad1 4 shifts", 32'(bus3.dout), 32'h3);
    check("pad1 4 shifts dut2", 32'(bus2.dout), 32'h3);

    // key event on the same edge as a reload
    send(8'hF0);
    @(negedge clock); hit = 1'b1; data = 8'h1A; strobe = 1'b1;
    @(negedge clock); hit = 1'b0; strobe = 1'b0;
    check("same-edge joy", 32'(bus3.joy[7:0]), 32'h10);
    check("same-edge old load", 32'(bus3.dout[0]), 32'h1);
    latch();
    check("next reload", 32'(bus3.dout[0]), 32'h0);

    // unmapped bytes
    send(8'hE1); send(8'hAA); send(8'hFA); send(8'hFE);
    send(8'hE0); send(8'h1A);
    check("unmapped", 32'(bus3.joy), 32'h101010);
    send(8'hE0); send(8'hE0); send(8'hF0); send(8'h75);
    check("E0 E0 then F0 75", 32'(bus3.joy), 32'h001010);

    // reset over a pending prefix and concurrent activity
    send(8'hE0);
    @(negedge clock); reset = 1'b1; hit = 1'b1; data = 8'h75; strobe = 1'b1; rd = 3'b111;
    @(negedge clock); reset = 1'b0; hit = 1'b0; strobe = 1'b0; rd = 3'b000;
    check("post-reset joy3", 32'(bus3.joy), 32'h0);
    check("post-reset dout3", 32'(bus3.dout), 32'h0);
    send(8'h75);
    check("prefix dropped joy3", 32'(bus3.joy), 32'h100000);
    check("prefix dropped joy2", 32'(bus2.joy), 32'h0);
    check("dout before strobe", 32'(bus3.dout), 32'h0);

    repeat (3) @(negedge clock);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
